// File: rtl/fetch_pkg.sv
// Shared fetch/decode types and constants.
// Pipe bundle, fetch FSM states, bus shapes.
package fetch_pkg;

  localparam int ILEN = 32;
  localparam logic [63:0] RESET_PC_DEF =
    64'h0000_0000_8000_0000;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
  typedef u64          addr_t;

  typedef struct packed {
    u1               valid;
    addr_t           pc;
    logic [ILEN-1:0] raw_instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    u1     valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    u1  addr_ok;
    u1  data_ok;
    u32 data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset value, +4 step,
// redirect load taking priority over the step.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,
  input  logic  load,
  input  addr_t target,
  output addr_t pc
);

  // Redirect wins over sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 64'd4;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage feeding decode.
// Holds bus address stable across redirects.
module fetch
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF,
  parameter int    INSTR_W  = ILEN
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ireq_valid,
  output logic [63:0]        ireq_addr,
  input  logic               iaddr_ok,
  input  logic               idata_ok,
  input  logic [INSTR_W-1:0] idata,
  input  logic               stall,
  input  logic               branch,
  input  logic [63:0]        PCbranch,
  output fetch_data_t        dataF
);

  fetch_state_t state;
  fetch_state_t state_n;
  fetch_data_t  skid;
  fetch_data_t  skid_n;
  fetch_data_t  data_n;
  addr_t        pc;
  addr_t        hold_addr;
  addr_t        hold_n;
  ibus_req_t    ireq;
  logic         consume;
  logic         redirect;
  logic         slot_free;
  logic         inc;
  logic         unused_addr_ok;

  assign unused_addr_ok = iaddr_ok;

  assign consume   = dataF.valid & ~stall;
  assign redirect  = branch & consume;
  assign slot_free = ~dataF.valid | consume;

  assign ireq.valid = reset & (state != HOLD);
  assign ireq.addr  = (state == FLUSH) ?
                      hold_addr : pc;

  assign ireq_valid = ireq.valid;
  assign ireq_addr  = ireq.addr;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (reset),
    .inc   (inc),
    .load  (redirect),
    .target(PCbranch),
    .pc    (pc)
  );

  // Next state, output slot, skid and flush address.
  always_comb begin
    state_n = state;
    data_n  = dataF;
    skid_n  = skid;
    hold_n  = hold_addr;
    inc     = 1'b0;
    if (redirect) begin
      data_n.valid = 1'b0;
      skid_n.valid = 1'b0;
      if (ireq.valid & ~idata_ok) begin
        state_n = FLUSH;
        hold_n  = ireq.addr;
      end else begin
        state_n = FETCH;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (idata_ok) begin
            inc = 1'b1;
            if (slot_free) begin
              data_n = '{1'b1, pc, idata};
            end else begin
              skid_n  = '{1'b1, pc, idata};
              state_n = HOLD;
            end
          end else if (consume) begin
            data_n.valid = 1'b0;
          end
        end
        HOLD: begin
          if (~stall) begin
            data_n       = skid;
            skid_n.valid = 1'b0;
            state_n      = FETCH;
          end
        end
        FLUSH: begin
          if (idata_ok) begin
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      dataF     <= '0;
      skid      <= '0;
      hold_addr <= '0;
    end else begin
      state     <= state_n;
      dataF     <= data_n;
      skid      <= skid_n;
      hold_addr <= hold_n;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Fetch stage bench: queue-based reference
// model plus directed literal checkpoints.
module tb_fetch;
  import fetch_pkg::*;

  localparam u64 RST_PC = 64'h8000_0000;

  typedef struct {
    u64 pc;
    u32 ins;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  u64          ireq_addr;
  logic        iaddr_ok;
  logic        idata_ok;
  logic [31:0] idata;
  logic        stall;
  logic        branch;
  u64          PCbranch;
  fetch_data_t dataF;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic m_rst   = 1'b1;
  u64   m_pc    = RST_PC;
  logic m_v     = 1'b0;
  u64   m_spc   = '0;
  u32   m_sins  = '0;
  ent_t m_pend[$];
  logic m_ghost = 1'b0;
  u64   m_gaddr = '0;
  int   cnt     = 0;
  int   lat     = 1;

  fetch dut (
    .clk       (clk),
    .reset     (reset),
    .ireq_valid(ireq_valid),
    .ireq_addr (ireq_addr),
    .iaddr_ok  (iaddr_ok),
    .idata_ok  (idata_ok),
    .idata     (idata),
    .stall     (stall),
    .branch    (branch),
    .PCbranch  (PCbranch),
    .dataF     (dataF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic u32 instr_of(u64 a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic m_req();
    return !m_rst && (m_pend.size() == 0);
  endfunction

  function automatic u64 m_addr();
    return m_ghost ? m_gaddr : m_pc;
  endfunction

  task automatic chk(input string nm,
                     input u64 got,
                     input u64 exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_rst   = 1'b1;
    m_pc    = RST_PC;
    m_v     = 1'b0;
    m_pend.delete();
    m_ghost = 1'b0;
    cnt     = 0;
  endtask

  task automatic m_step(input logic s,
                        input logic b,
                        input u64   t,
                        input logic ok,
                        input u32   d,
                        input logic rq,
                        input u64   ra);
    logic take;
    take = m_v && !s;
    if (m_rst) return;
    if (take && b) begin
      m_pc    = t;
      m_v     = 1'b0;
      m_pend.delete();
      m_ghost = rq && !ok;
      m_gaddr = ra;
    end else if (m_ghost) begin
      if (ok) m_ghost = 1'b0;
    end else if (m_pend.size() != 0) begin
      if (!s) begin
        m_v    = 1'b1;
        m_spc  = m_pend[0].pc;
        m_sins = m_pend[0].ins;
        void'(m_pend.pop_front());
      end
    end else if (rq && ok) begin
      if (!m_v || take) begin
        m_v    = 1'b1;
        m_spc  = m_pc;
        m_sins = d;
      end else begin
        m_pend.push_back('{m_pc, d});
      end
      m_pc = m_pc + 64'd4;
    end else if (take) begin
      m_v = 1'b0;
    end
  endtask

  // One clock: drive inputs, bus reply,
  // then advance the model at the edge.
  task automatic cyc(input logic s,
                     input logic b,
                     input u64   t);
    logic rq;
    u64   ra;
    logic ok;
    u32   d;
    rq = m_req();
    ra = m_addr();
    ok = rq && (cnt + 1 >= lat);
    d  = ok ? instr_of(ra) : 32'hDEAD_BEEF;
    stall    = s;
    branch   = b;
    PCbranch = t;
    iaddr_ok = rq;
    idata_ok = ok;
    idata    = d;
    @(posedge clk);
    m_step(s, b, t, ok, d, rq, ra);
    if (rq) cnt = ok ? 0 : cnt + 1;
    else cnt = 0;
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ireq_valid", 64'(ireq_valid),
        64'(m_req()));
    if (m_req())
      chk("ireq_addr", ireq_addr, m_addr());
    chk("dataF.valid", 64'(dataF.valid),
        64'(m_v));
    if (m_v) begin
      chk("dataF.pc", dataF.pc, m_spc);
      chk("dataF.instr",
          64'(dataF.raw_instr), 64'(m_sins));
    end
  end

  initial begin
    reset    = 1'b0;
    stall    = 1'b0;
    branch   = 1'b0;
    PCbranch = '0;
    iaddr_ok = 1'b0;
    idata_ok = 1'b0;
    idata    = '0;
    m_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst ireq_valid", 64'(ireq_valid), 0);
    chk("rst valid", 64'(dataF.valid), 0);
    reset = 1'b1;
    m_rst = 1'b0;
    #1;
    // streaming, one per cycle
    chk("c0 addr", ireq_addr, 64'h8000_0000);
    chk("c0 req", 64'(ireq_valid), 1);
    cyc(0, 0, 0);
    chk("c1 addr", ireq_addr, 64'h8000_0004);
    chk("c1 pc", dataF.pc, 64'h8000_0000);
    // stall three cycles, response to skid
    cyc(1, 0, 0);
    chk("c2 req", 64'(ireq_valid), 0);
    chk("c2 pc", dataF.pc, 64'h8000_0000);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("c4 pc", dataF.pc, 64'h8000_0000);
    cyc(0, 0, 0);
    chk("c5 pc", dataF.pc, 64'h8000_0004);
    chk("c5 addr", ireq_addr, 64'h8000_0008);
    // redirect with same-cycle response
    cyc(0, 1, 64'h8000_0100);
    chk("c6 addr", ireq_addr, 64'h8000_0100);
    chk("c6 valid", 64'(dataF.valid), 0);
    cyc(0, 0, 0);
    // redirect while request outstanding
    lat = 3;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("c10 pc", dataF.pc, 64'h8000_0104);
    chk("c10 addr", ireq_addr, 64'h8000_0108);
    cyc(0, 1, 64'h8000_0200);
    chk("c11 addr", ireq_addr, 64'h8000_0108);
    chk("c11 valid", 64'(dataF.valid), 0);
    cyc(0, 0, 0);
    chk("c12 addr", ireq_addr, 64'h8000_0108);
    cyc(0, 0, 0);
    chk("c13 addr", ireq_addr, 64'h8000_0200);
    chk("c13 valid", 64'(dataF.valid), 0);
    // branch under stall is ignored
    lat = 1;
    cyc(0, 0, 0);
    chk("c14 pc", dataF.pc, 64'h8000_0200);
    cyc(1, 1, 64'h8000_0300);
    chk("c15 req", 64'(ireq_valid), 0);
    chk("c15 pc", dataF.pc, 64'h8000_0200);
    cyc(0, 1, 64'h8000_0300);
    chk("c16 addr", ireq_addr, 64'h8000_0300);
    chk("c16 valid", 64'(dataF.valid), 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    // reset while holding
    reset = 1'b0;
    m_reset();
    #1;
    chk("hold rst req", 64'(ireq_valid), 0);
    chk("hold rst valid", 64'(dataF.valid), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    reset = 1'b1;
    m_rst = 1'b0;
    #1;
    chk("r0 addr", ireq_addr, 64'h8000_0000);
    chk("r0 valid", 64'(dataF.valid), 0);
    cyc(0, 0, 0);
    chk("r1 pc", dataF.pc, 64'h8000_0000);
    // wrap at top of address space
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("r2 addr", ireq_addr,
        64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0);
    chk("r3 addr", ireq_addr, 64'h0);
    chk("r3 pc", dataF.pc,
        64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0);
    chk("r4 pc", dataF.pc, 64'h0);
    // mixed stalls, latencies, odd targets
    for (int i = 0; i < 48; i++) begin
      lat = 1 + (i / 8) % 3;
      cyc((i % 5 == 2) || (i % 7 == 3),
          (i % 11 == 6),
          64'h8000_1000 + 64'(i * 16) +
          ((i % 2 == 1) ? 64'd2 : 64'd0));
    end
    // reset with a slow request in flight
    lat = 3;
    cyc(0, 0, 0);
    reset = 1'b0;
    m_reset();
    #1;
    chk("fl rst req", 64'(ireq_valid), 0);
    chk("fl rst valid", 64'(dataF.valid), 0);
    cyc(0, 0, 0);
    reset = 1'b1;
    m_rst = 1'b0;
    #1;
    chk("fl r0 addr", ireq_addr, 64'h8000_0000);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
